// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: skip condition codes and
// the per-cycle action chosen by the priority mux.
package pc_pkg;

    localparam logic [2:0] SK_ISZ = 3'd0;
    localparam logic [2:0] SK_SPA = 3'd1;
    localparam logic [2:0] SK_SNA = 3'd2;
    localparam logic [2:0] SK_SZA = 3'd3;
    localparam logic [2:0] SK_SZE = 3'd4;

    typedef enum logic [2:0] {
        ACT_CLR,
        ACT_IRQ,
        ACT_RET,
        ACT_CALL,
        ACT_LD,
        ACT_ADV
    } action_t;

    // Highest-priority request wins; everything below it is ignored this cycle.
    function automatic action_t pick_action(input logic clr, input logic irq,
                                            input logic ret, input logic call,
                                            input logic ld);
        if (clr)       return ACT_CLR;
        else if (irq)  return ACT_IRQ;
        else if (ret)  return ACT_RET;
        else if (call) return ACT_CALL;
        else if (ld)   return ACT_LD;
        else           return ACT_ADV;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the sequencer and the program-counter unit.
interface pc_unit_if #(
    parameter int AW    = 12,
    parameter int DW    = 16,
    parameter int DEPTH = 4
);
    localparam int DPW = $clog2(DEPTH + 1);

    logic            pc_clr;
    logic            pc_ld;
    logic [AW-1:0]   ld_addr;
    logic            pc_inr;
    logic            skip_en;
    logic [2:0]      skip_sel;
    logic [DW-1:0]   ac;
    logic [DW-1:0]   dr;
    logic            e;
    logic            call;
    logic            ret;
    logic            irq;
    logic [AW-1:0]   pc;
    logic            skip_taken;
    logic [DPW-1:0]  stk_depth;
    logic            stk_ovf;
    logic            stk_unf;

    modport master (
        output pc_clr, pc_ld, ld_addr, pc_inr, skip_en, skip_sel,
               ac, dr, e, call, ret, irq,
        input  pc, skip_taken, stk_depth, stk_ovf, stk_unf
    );

    modport slave (
        input  pc_clr, pc_ld, ld_addr, pc_inr, skip_en, skip_sel,
               ac, dr, e, call, ret, irq,
        output pc, skip_taken, stk_depth, stk_ovf, stk_unf
    );

endinterface

// File: rtl/pc_unit_ras_stack.sv
// Return-address LIFO. Pushes while full are dropped and pops while empty
// are ignored; the owner decides what to flag.
module ras_stack #(
    parameter int AW    = 12,
    parameter int DEPTH = 4,
    localparam int DPW  = $clog2(DEPTH + 1)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           flush,
    input  logic           push,
    input  logic           pop,
    input  logic [AW-1:0]  din,
    output logic [AW-1:0]  dout,
    output logic [DPW-1:0] depth,
    output logic           full,
    output logic           empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign full   = (depth == DPW'(DEPTH));
    assign empty  = (depth == '0);
    assign wr_idx = IW'(depth);
    assign rd_idx = IW'(depth - DPW'(1));
    assign dout   = empty ? '0 : mem[rd_idx];

    // Storage needs no reset: entries beyond depth are never read.
    always_ff @(posedge CLK) begin
        if (!flush && push && !full)
            mem[wr_idx] <= din;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            depth <= '0;
        else if (flush)
            depth <= '0;
        else if (push && !full)
            depth <= depth + DPW'(1);
        else if (!push && pop && !empty)
            depth <= depth - DPW'(1);
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with skip-on-condition, double advance, interrupt vectoring
// and a hardware return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int VEC   = 1
) (
    input logic       CLK,
    input logic       RST_N,
    pc_unit_if.slave  bus
);

    localparam int DPW = $clog2(DEPTH + 1);

    action_t       action;
    logic          cond;
    logic [1:0]    inc;
    logic [AW-1:0] pc_adv;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] pc_nxt;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_data;
    logic          set_ovf;
    logic          set_unf;
    logic [AW-1:0] top;
    logic          full;
    logic          empty;

    always_comb begin
        cond = 1'b0;
        case (bus.skip_sel)
            SK_ISZ:  cond = (bus.dr == '0);
            SK_SPA:  cond = ~bus.ac[DW-1];
            SK_SNA:  cond = bus.ac[DW-1];
            SK_SZA:  cond = (bus.ac == '0);
            SK_SZE:  cond = ~bus.e;
            default: cond = 1'b0;
        endcase
    end

    assign bus.skip_taken = bus.skip_en & cond;

    assign action   = pick_action(bus.pc_clr, bus.irq, bus.ret, bus.call, bus.pc_ld);
    assign inc      = {1'b0, bus.pc_inr} + {1'b0, bus.skip_taken};
    assign pc_adv   = bus.pc + AW'(inc);
    assign pc_plus1 = bus.pc + AW'(1);

    // Push/pop requests only reach the stack for the winning action.
    always_comb begin
        pc_nxt    = bus.pc;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = pc_plus1;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        case (action)
            ACT_CLR: pc_nxt = '0;
            ACT_IRQ: begin
                pc_nxt    = AW'(VEC);
                push      = 1'b1;
                push_data = bus.pc;
                set_ovf   = full;
            end
            ACT_RET: begin
                if (!empty) begin
                    pc_nxt = top;
                    pop    = 1'b1;
                end else begin
                    set_unf = 1'b1;
                end
            end
            ACT_CALL: begin
                pc_nxt  = bus.ld_addr;
                push    = 1'b1;
                set_ovf = full;
            end
            ACT_LD:  pc_nxt = bus.ld_addr;
            default: pc_nxt = pc_adv;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.pc      <= '0;
            bus.stk_ovf <= 1'b0;
            bus.stk_unf <= 1'b0;
        end else if (action == ACT_CLR) begin
            bus.pc      <= '0;
            bus.stk_ovf <= 1'b0;
            bus.stk_unf <= 1'b0;
        end else begin
            bus.pc      <= pc_nxt;
            bus.stk_ovf <= bus.stk_ovf | set_ovf;
            bus.stk_unf <= bus.stk_unf | set_unf;
        end
    end

    ras_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ras (
        .CLK   (CLK),
        .RST_N (RST_N),
        .flush (bus.pc_clr),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (top),
        .depth (bus.stk_depth),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus pushes hand-computed expectations
// tagged with the cycle they apply to; a negedge monitor pops and compares.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int VEC   = 1;
    localparam int DPW   = $clog2(DEPTH + 1);

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    pc_unit_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    pc_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .VEC(VEC)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct packed {
        logic          clr;
        logic          irq;
        logic          ret;
        logic          call;
        logic          ld;
        logic [AW-1:0] addr;
        logic          inr;
        logic          sken;
        logic [2:0]    sel;
        logic [DW-1:0] ac;
        logic [DW-1:0] dr;
        logic          e;
    } ctrl_t;

    typedef struct {
        string          name;
        int             tag;
        bit             is_skip;
        logic           skip;
        logic [AW-1:0]  pc;
        logic [DPW-1:0] depth;
        logic           ovf;
        logic           unf;
    } exp_t;

    exp_t exp_q[$];
    exp_t item;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic ctrl_t f_idle();
        ctrl_t c;
        c    = '0;
        c.ac = 16'h1234;
        c.dr = 16'h0001;
        c.e  = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t f_ld(input logic [AW-1:0] a);
        ctrl_t c;
        c      = f_idle();
        c.ld   = 1'b1;
        c.addr = a;
        return c;
    endfunction

    function automatic ctrl_t f_call(input logic [AW-1:0] a);
        ctrl_t c;
        c      = f_idle();
        c.call = 1'b1;
        c.addr = a;
        return c;
    endfunction

    function automatic ctrl_t f_ret();
        ctrl_t c;
        c     = f_idle();
        c.ret = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t f_inr();
        ctrl_t c;
        c     = f_idle();
        c.inr = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t f_skip(input logic inr, input logic [2:0] sel,
                                     input logic [DW-1:0] ac, input logic [DW-1:0] dr,
                                     input logic e);
        ctrl_t c;
        c      = f_idle();
        c.inr  = inr;
        c.sken = 1'b1;
        c.sel  = sel;
        c.ac   = ac;
        c.dr   = dr;
        c.e    = e;
        return c;
    endfunction

    task automatic applyStimulus(input ctrl_t c, output int tag);
        @(posedge CLK);
        #1;
        bus.pc_clr   = c.clr;
        bus.irq      = c.irq;
        bus.ret      = c.ret;
        bus.call     = c.call;
        bus.pc_ld    = c.ld;
        bus.ld_addr  = c.addr;
        bus.pc_inr   = c.inr;
        bus.skip_en  = c.sken;
        bus.skip_sel = c.sel;
        bus.ac       = c.ac;
        bus.dr       = c.dr;
        bus.e        = c.e;
        tag          = cyc;
    endtask

    task automatic expectState(input string name, input int tag, input logic [AW-1:0] pc,
                               input logic [DPW-1:0] d, input logic o, input logic u);
        exp_t x;
        x.name = name; x.tag = tag; x.is_skip = 1'b0; x.skip = 1'b0;
        x.pc = pc; x.depth = d; x.ovf = o; x.unf = u;
        exp_q.push_back(x);
    endtask

    task automatic expectSkip(input string name, input int tag, input logic s);
        exp_t x;
        x.name = name; x.tag = tag; x.is_skip = 1'b1; x.skip = s;
        x.pc = '0; x.depth = '0; x.ovf = 1'b0; x.unf = 1'b0;
        exp_q.push_back(x);
    endtask

    task automatic doOp(input string name, input ctrl_t c, input logic [AW-1:0] pc,
                        input logic [DPW-1:0] d, input logic o, input logic u);
        int t;
        applyStimulus(c, t);
        expectState(name, t + 1, pc, d, o, u);
    endtask

    task automatic doSkip(input string name, input ctrl_t c, input logic s,
                          input logic [AW-1:0] pc, input logic [DPW-1:0] d,
                          input logic o, input logic u);
        int t;
        applyStimulus(c, t);
        expectSkip({name, "_skip"}, t, s);
        expectState(name, t + 1, pc, d, o, u);
    endtask

    task automatic checkOutput(input exp_t x);
        checks++;
        if (x.tag != cyc) begin
            $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", x.name, cyc, x.tag);
        end else if (x.is_skip) begin
            if (bus.skip_taken === x.skip) passes++;
            else $display("[TB] FAIL %s: skip_taken=%b required %b", x.name, bus.skip_taken, x.skip);
        end else begin
            if (bus.pc === x.pc && bus.stk_depth === x.depth &&
                bus.stk_ovf === x.ovf && bus.stk_unf === x.unf)
                passes++;
            else
                $display("[TB] FAIL %s: pc=%h depth=%0d ovf=%b unf=%b, required pc=%h depth=%0d ovf=%b unf=%b",
                         x.name, bus.pc, bus.stk_depth, bus.stk_ovf, bus.stk_unf,
                         x.pc, x.depth, x.ovf, x.unf);
        end
    endtask

    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
            item = exp_q.pop_front();
            checkOutput(item);
        end
    end

    initial begin
        int    t;
        ctrl_t c;
        RST_N = 1'b0;
        c = f_idle();
        bus.pc_clr = 1'b0; bus.irq = 1'b0; bus.ret = 1'b0; bus.call = 1'b0;
        bus.pc_ld = 1'b0; bus.ld_addr = '0; bus.pc_inr = 1'b0; bus.skip_en = 1'b0;
        bus.skip_sel = '0; bus.ac = c.ac; bus.dr = c.dr; bus.e = c.e;

        applyStimulus(f_idle(), t);
        expectState("reset", t, 12'h000, 3'd0, 1'b0, 1'b0);
        @(negedge CLK);
        #1 RST_N = 1'b1;

        doOp("inr1", f_inr(), 12'h001, 3'd0, 1'b0, 1'b0);
        doOp("inr2", f_inr(), 12'h002, 3'd0, 1'b0, 1'b0);
        doOp("inr3", f_inr(), 12'h003, 3'd0, 1'b0, 1'b0);
        applyStimulus(f_idle(), t);
        applyStimulus(f_idle(), t);
        RST_N = 1'b0;
        expectState("async_rst", t, 12'h000, 3'd0, 1'b0, 1'b0);
        @(negedge CLK);
        #1 RST_N = 1'b1;

        doOp  ("ld010a", f_ld(12'h010), 12'h010, 3'd0, 1'b0, 1'b0);
        doSkip("sza_dbl", f_skip(1'b1, SK_SZA, 16'h0000, 16'h0001, 1'b1), 1'b1, 12'h012, 3'd0, 1'b0, 1'b0);
        doOp  ("ld010b", f_ld(12'h010), 12'h010, 3'd0, 1'b0, 1'b0);
        doSkip("sna_dbl", f_skip(1'b1, SK_SNA, 16'h8000, 16'h0001, 1'b1), 1'b1, 12'h012, 3'd0, 1'b0, 1'b0);
        doOp  ("ld010c", f_ld(12'h010), 12'h010, 3'd0, 1'b0, 1'b0);
        doSkip("sel5", f_skip(1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0), 1'b0, 12'h011, 3'd0, 1'b0, 1'b0);
        doSkip("spa_neg", f_skip(1'b1, SK_SPA, 16'h8000, 16'h0001, 1'b1), 1'b0, 12'h012, 3'd0, 1'b0, 1'b0);
        doSkip("isz_only", f_skip(1'b0, SK_ISZ, 16'h1234, 16'h0000, 1'b1), 1'b1, 12'h013, 3'd0, 1'b0, 1'b0);
        doSkip("sze_e1", f_skip(1'b1, SK_SZE, 16'h1234, 16'h0001, 1'b1), 1'b0, 12'h014, 3'd0, 1'b0, 1'b0);
        doSkip("sze_e0", f_skip(1'b0, SK_SZE, 16'h1234, 16'h0001, 1'b0), 1'b1, 12'h015, 3'd0, 1'b0, 1'b0);

        c = f_skip(1'b1, SK_SZA, 16'h0000, 16'h0001, 1'b1);
        c.ld = 1'b1; c.addr = 12'hFFF;
        doSkip("ld_wins", c, 1'b1, 12'hFFF, 3'd0, 1'b0, 1'b0);
        doSkip("wrap", f_skip(1'b1, SK_SZA, 16'h0000, 16'h0001, 1'b1), 1'b1, 12'h001, 3'd0, 1'b0, 1'b0);

        doOp("ld020", f_ld(12'h020), 12'h020, 3'd0, 1'b0, 1'b0);
        doOp("call300", f_call(12'h300), 12'h300, 3'd1, 1'b0, 1'b0);
        doOp("ret021", f_ret(), 12'h021, 3'd0, 1'b0, 1'b0);
        doOp("ret_empty", f_ret(), 12'h021, 3'd0, 1'b0, 1'b1);

        doOp("ld100", f_ld(12'h100), 12'h100, 3'd0, 1'b0, 1'b1);
        doOp("call1", f_call(12'h101), 12'h101, 3'd1, 1'b0, 1'b1);
        doOp("call2", f_call(12'h102), 12'h102, 3'd2, 1'b0, 1'b1);
        doOp("call3", f_call(12'h103), 12'h103, 3'd3, 1'b0, 1'b1);
        doOp("call4", f_call(12'h104), 12'h104, 3'd4, 1'b0, 1'b1);
        doOp("call5_ovf", f_call(12'h105), 12'h105, 3'd4, 1'b1, 1'b1);
        doOp("ret104", f_ret(), 12'h104, 3'd3, 1'b1, 1'b1);
        doOp("ret103", f_ret(), 12'h103, 3'd2, 1'b1, 1'b1);
        doOp("ret102", f_ret(), 12'h102, 3'd1, 1'b1, 1'b1);
        doOp("ret101", f_ret(), 12'h101, 3'd0, 1'b1, 1'b1);

        doOp("ld050", f_ld(12'h050), 12'h050, 3'd0, 1'b1, 1'b1);
        c = f_ld(12'h777);
        c.irq = 1'b1; c.ret = 1'b1;
        doOp("irq_prio", c, 12'h001, 3'd1, 1'b1, 1'b1);
        doOp("ret050", f_ret(), 12'h050, 3'd0, 1'b1, 1'b1);
        c = f_inr();
        c.clr = 1'b1; c.irq = 1'b1;
        doOp("clr", c, 12'h000, 3'd0, 1'b0, 1'b0);
        doOp("idle_end", f_idle(), 12'h000, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain_timeout: %0d expectations pending, required 0", exp_q.size());
        end
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
